// File: rtl/updown_counter_nbit_pkg.sv
// updown_counter_nbit_pkg: shared modes, sync-operation encoding and full-adder helpers.
package updown_counter_nbit_pkg;

    localparam bit MODE_WRAP = 1'b0;
    localparam bit MODE_SAT  = 1'b1;

    // Synchronous operation selected on an edge, in priority order clr > load > en.
    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLR,
        OP_LOAD,
        OP_STEP
    } op_e;

    function automatic logic fa_sum(input logic a, input logic b, input logic ci);
        return a ^ b ^ ci;
    endfunction

    function automatic logic fa_carry(input logic a, input logic b, input logic ci);
        return (a & b) | (ci & (a ^ b));
    endfunction

endpackage

// File: rtl/updown_counter_nbit_incdec.sv
// incdec_nbit: ripple chain of full adders producing a+1 (up=1) or a-1 (up=0), modulo 2**WIDTH.
module incdec_nbit
    import updown_counter_nbit_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] a,
    input  logic             up,
    output logic [WIDTH-1:0] y
);

    logic [WIDTH-1:0] c;

    // +1 is b=0 with carry-in 1; -1 is b=all-ones with carry-in 0.
    assign c[0] = up;

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        assign y[i] = fa_sum(a[i], ~up, c[i]);
        if (i < WIDTH - 1) begin : g_c
            assign c[i+1] = fa_carry(a[i], ~up, c[i]);
        end
    end

endmodule

// File: rtl/updown_counter_nbit.sv
// updown_counter_nbit: registered up/down counter with clear, clamped load, modulus limit,
// wrap/saturate mode, one-cycle carry pulse and sticky overflow.
module updown_counter_nbit
    import updown_counter_nbit_pkg::*;
#(
    parameter int WIDTH    = 4,
    parameter int MAX_VAL  = 2**WIDTH - 1,
    parameter bit SATURATE = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             carry,
    output logic             ovf,
    output logic             at_max,
    output logic             at_min
);

    localparam logic [WIDTH-1:0] MAX = MAX_VAL[WIDTH-1:0];

    op_e              op;
    logic             limit;
    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] next_count;
    logic             next_carry;
    logic             next_ovf;

    incdec_nbit #(.WIDTH(WIDTH)) u_incdec (
        .a  (count),
        .up (up),
        .y  (step_val)
    );

    assign at_max = count == MAX;
    assign at_min = count == '0;
    assign limit  = up ? at_max : at_min;
    assign op     = clr ? OP_CLR : load ? OP_LOAD : en ? OP_STEP : OP_HOLD;

    // The limit compare, not the chain carry-out, decides wrap so moduli below 2**WIDTH work.
    always_comb begin
        next_count = count;
        next_carry = 1'b0;
        next_ovf   = ovf;
        unique case (op)
            OP_CLR: begin
                next_count = '0;
                next_ovf   = 1'b0;
            end
            OP_LOAD: next_count = (load_val > MAX) ? MAX : load_val;
            OP_STEP: begin
                next_carry = limit;
                next_ovf   = ovf | limit;
                next_count = !limit ? step_val : SATURATE ? count : up ? '0 : MAX;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            carry <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            count <= next_count;
            carry <= next_carry;
            ovf   <= next_ovf;
        end
    end

endmodule

// File: tb/tb_updown_counter_nbit.sv
// tb_updown_counter_nbit: scoreboard bench driving three counter variants (wrap/15, wrap/9, saturate/15)
// with shared directed and random stimulus against an arithmetic reference model.
module tb_updown_counter_nbit;

    typedef struct packed {
        logic [2:0][3:0] cnt;
        logic [2:0]      cy;
        logic [2:0]      ov;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       clr = 1'b0;
    logic       load = 1'b0;
    logic [3:0] load_val = '0;
    logic       en = 1'b0;
    logic       up = 1'b0;

    logic [3:0] cnt_o [3];
    logic       cy_o  [3];
    logic       ov_o  [3];
    logic       amx_o [3];
    logic       amn_o [3];

    int   checks = 0;
    int   errors = 0;
    exp_t expq[$];
    int   m_cnt [3];
    bit   m_ovf [3];

    updown_counter_nbit #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b0)) u_wrap15 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_o[0]), .carry(cy_o[0]), .ovf(ov_o[0]), .at_max(amx_o[0]), .at_min(amn_o[0]));

    updown_counter_nbit #(.WIDTH(4), .MAX_VAL(9), .SATURATE(1'b0)) u_wrap9 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_o[1]), .carry(cy_o[1]), .ovf(ov_o[1]), .at_max(amx_o[1]), .at_min(amn_o[1]));

    updown_counter_nbit #(.WIDTH(4), .MAX_VAL(15), .SATURATE(1'b1)) u_sat15 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .load(load), .load_val(load_val), .en(en), .up(up),
        .count(cnt_o[2]), .carry(cy_o[2]), .ovf(ov_o[2]), .at_max(amx_o[2]), .at_min(amn_o[2]));

    always #5 clk = ~clk;

    function automatic int mx(input int k);
        return (k == 1) ? 9 : 15;
    endfunction

    function automatic bit sat(input int k);
        return k == 2;
    endfunction

    task automatic chk(input string nm, input int k, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s dut%0d at %0t: got %0d expected %0d", nm, k, $time, act, exp);
        end
    endtask

    // Issue one edge worth of inputs and queue the model's post-edge outputs for every variant.
    task automatic step(input bit c, input bit l, input logic [3:0] lv, input bit e, input bit u);
        exp_t x;
        @(negedge clk);
        clr = c; load = l; load_val = lv; en = e; up = u;
        for (int k = 0; k < 3; k++) begin
            bit cy;
            cy = 1'b0;
            if (c) begin
                m_cnt[k] = 0;
                m_ovf[k] = 1'b0;
            end else if (l) begin
                m_cnt[k] = (int'(lv) > mx(k)) ? mx(k) : int'(lv);
            end else if (e && u) begin
                if (m_cnt[k] == mx(k)) begin
                    cy = 1'b1;
                    m_cnt[k] = sat(k) ? mx(k) : 0;
                end else m_cnt[k] = m_cnt[k] + 1;
            end else if (e) begin
                if (m_cnt[k] == 0) begin
                    cy = 1'b1;
                    m_cnt[k] = sat(k) ? 0 : mx(k);
                end else m_cnt[k] = m_cnt[k] - 1;
            end
            m_ovf[k] = m_ovf[k] | cy;
            x.cnt[k] = 4'(m_cnt[k]);
            x.cy[k]  = cy;
            x.ov[k]  = m_ovf[k];
        end
        expq.push_back(x);
    endtask

    // Assert reset between edges and check outputs clear before any clock edge.
    task automatic async_reset();
        @(negedge clk);
        clr = 1'b0; load = 1'b0; en = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rst_count", k, int'(cnt_o[k]), 0);
            chk("rst_carry", k, int'(cy_o[k]), 0);
            chk("rst_ovf", k, int'(ov_o[k]), 0);
            m_cnt[k] = 0;
            m_ovf[k] = 1'b0;
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin : monitor
        exp_t x;
        forever begin
            @(posedge clk);
            #1;
            if (expq.size() > 0) begin
                x = expq.pop_front();
                for (int k = 0; k < 3; k++) begin
                    chk("count", k, int'(cnt_o[k]), int'(x.cnt[k]));
                    chk("carry", k, int'(cy_o[k]), int'(x.cy[k]));
                    chk("ovf", k, int'(ov_o[k]), int'(x.ov[k]));
                    chk("at_max", k, int'(amx_o[k]), int'(x.cnt[k]) == mx(k) ? 1 : 0);
                    chk("at_min", k, int'(amn_o[k]), x.cnt[k] == 4'd0 ? 1 : 0);
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        async_reset();
        // reset mid-count at 9, then resume from 0
        step(0, 1, 4'd8, 0, 0);
        step(0, 0, 4'd0, 1, 1);
        async_reset();
        step(0, 0, 4'd0, 1, 1);
        // wrap from 14
        step(0, 1, 4'd14, 0, 0);
        repeat (3) step(0, 0, 4'd0, 1, 1);
        // decimal modulus, then down from 0
        step(0, 1, 4'd8, 0, 0);
        repeat (3) step(0, 0, 4'd0, 1, 1);
        step(1, 0, 4'd0, 0, 0);
        step(0, 0, 4'd0, 1, 0);
        // saturate at top, then at bottom
        step(0, 1, 4'd15, 0, 0);
        repeat (3) step(0, 0, 4'd0, 1, 1);
        step(1, 0, 4'd0, 0, 0);
        repeat (2) step(0, 0, 4'd0, 1, 0);
        // priority: clr over load over en
        step(1, 1, 4'd7, 1, 1);
        step(0, 1, 4'd7, 1, 1);
        // load clamp and exhaustive load x direction sweep
        step(0, 1, 4'd13, 0, 0);
        for (int v = 0; v < 16; v++) begin
            for (int u = 0; u < 2; u++) begin
                step(0, 1, 4'(v), 0, 0);
                step(0, 0, 4'd0, 1, u[0]);
                step(0, 0, 4'd0, 1, u[0]);
            end
        end
        // random traffic with occasional asynchronous resets
        for (int n = 0; n < 800; n++) begin
            if (n % 250 == 125) async_reset();
            step($urandom_range(0, 19) == 0, $urandom_range(0, 5) == 0, 4'($urandom),
                 $urandom_range(0, 3) != 0, 1'($urandom));
        end
        step(0, 0, 4'd0, 0, 0);
        repeat (3) @(negedge clk);
        chk("drain", 0, expq.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
